// File: rtl/nco_pkg.sv
// nco_pkg: shared types and constants for the multi-channel NCO.
// Contents: quadrant enum, config FSM states, LFSR constants, amplitude helper.
package nco_pkg;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_e;

    typedef enum logic {
        CFG_IDLE  = 1'b0,
        CFG_APPLY = 1'b1
    } cfg_state_e;

    // Galois form of x^16+x^14+x^13+x^11+1, right-shifting
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    // Peak sample magnitude for a signed OUT_W-bit output
    function automatic int nco_amp(input int out_w);
        return (1 << (out_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/nco_multi_if.sv
// nco_multi_if: enable, configuration handshake and sample bus of nco_multi.
// master drives en/cfg_*, slave (the NCO) drives cfg_ready/sin/cos/out_valid.
interface nco_multi_if #(
    parameter int NUM_CH = 2,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 17
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                      en;
    logic                      cfg_valid;
    logic                      cfg_ready;
    logic [CH_W-1:0]           cfg_ch;
    logic [ACC_W-1:0]          cfg_freq;
    logic [ACC_W-1:0]          cfg_phase;
    logic                      cfg_sync;
    logic [NUM_CH*OUT_W-1:0]   sin;
    logic [NUM_CH*OUT_W-1:0]   cos;
    logic                      out_valid;

    modport master (
        output en, cfg_valid, cfg_ch, cfg_freq, cfg_phase, cfg_sync,
        input  cfg_ready, sin, cos, out_valid
    );

    modport slave (
        input  en, cfg_valid, cfg_ch, cfg_freq, cfg_phase, cfg_sync,
        output cfg_ready, sin, cos, out_valid
    );

endinterface

// File: rtl/nco_quarter_lut.sv
// nco_quarter_lut: quarter-wave sine ROM, Q+1 entries, two registered reads.
// Ports: i_clk; i_idx_s/i_idx_c folded indices 0..Q; o_mag_s/o_mag_c magnitudes.
module nco_quarter_lut
    import nco_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int OUT_W  = 17
) (
    input  logic              i_clk,
    input  logic [ADDR_W-2:0] i_idx_s,
    input  logic [ADDR_W-2:0] i_idx_c,
    output logic [OUT_W-2:0]  o_mag_s,
    output logic [OUT_W-2:0]  o_mag_c
);
    localparam int Q = 1 << (ADDR_W - 2);
    localparam int A = nco_amp(OUT_W);

    function automatic logic [OUT_W-2:0] lut_entry(input int k);
        real x;
        x = real'(A) * $sin(3.141592653589793 * real'(k) / real'(2 * Q));
        return (OUT_W-1)'($rtoi(x + 0.5));
    endfunction

    logic [OUT_W-2:0] w_rom [0:Q];

    for (genvar k = 0; k <= Q; k++) begin : g_rom
        localparam logic [OUT_W-2:0] V = lut_entry(k);
        assign w_rom[k] = V;
    end

    always_ff @(posedge i_clk) begin
        o_mag_s <= w_rom[i_idx_s];
        o_mag_c <= w_rom[i_idx_c];
    end

endmodule

// File: rtl/nco_multi.sv
// nco_multi: NUM_CH parallel quadrature NCOs, 3-stage pipeline, run-time config.
// Ports: M100CLK, reset (async high), bus (nco_multi_if.slave). Macro NCO_DITHER_EN.
module nco_multi
    import nco_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 12,
    parameter int OUT_W  = 17
) (
    input  logic       M100CLK,
    input  logic       reset,
    nco_multi_if.slave bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int Q    = 1 << (ADDR_W - 2);

    cfg_state_e r_state;
    cfg_state_e w_state_nx;
    logic       w_accept;
    logic [2:0] r_vld;

    always_ff @(posedge M100CLK or posedge reset) begin
        if (reset) r_state <= CFG_APPLY;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx    = r_state;
        bus.cfg_ready = 1'b0;
        unique case (r_state)
            CFG_IDLE: begin
                bus.cfg_ready = 1'b1;
                if (bus.cfg_valid) w_state_nx = CFG_APPLY;
            end
            CFG_APPLY: w_state_nx = CFG_IDLE;
            default:   w_state_nx = CFG_IDLE;
        endcase
    end

    assign w_accept = bus.cfg_valid & bus.cfg_ready;

    always_ff @(posedge M100CLK or posedge reset) begin
        if (reset) r_vld <= '0;
        else       r_vld <= {r_vld[1:0], bus.en};
    end

    assign bus.out_valid = r_vld[2];

    // Map a full-circle address onto the quarter-wave index 0..Q
    function automatic logic [ADDR_W-2:0] fold(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-2:0] k;
        k    = {1'b0, a[ADDR_W-3:0]};
        fold = k;
        unique case (quad_e'(a[ADDR_W-1 -: 2]))
            Q1, Q3:  fold = (ADDR_W-1)'(Q) - k;
            default: fold = k;
        endcase
    endfunction

`ifdef NCO_DITHER_EN
    localparam int DW = ((ACC_W - ADDR_W) > 16) ? 16 : (ACC_W - ADDR_W);
    logic [15:0] r_lfsr;

    always_ff @(posedge M100CLK or posedge reset) begin
        if (reset)       r_lfsr <= LFSR_SEED;
        else if (bus.en) r_lfsr <= {1'b0, r_lfsr[15:1]}
                                   ^ (r_lfsr[0] ? LFSR_POLY : 16'h0);
    end
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [ACC_W-1:0]  r_acc;
        logic [ACC_W-1:0]  r_freq;
        logic [ACC_W-1:0]  r_poff;
        logic [ACC_W-1:0]  w_p;
        logic              w_sel;
        logic              w_unused_p;
        logic [ADDR_W-1:0] r_addr;
        logic [ADDR_W-1:0] w_addr_c;
        logic [ADDR_W-2:0] w_idx_s;
        logic [ADDR_W-2:0] w_idx_c;
        logic              r_neg_s;
        logic              r_neg_c;
        logic [OUT_W-2:0]  w_mag_s;
        logic [OUT_W-2:0]  w_mag_c;
        logic [OUT_W-1:0]  r_sin;
        logic [OUT_W-1:0]  r_cos;

        // Out-of-range channel numbers match no channel and write nothing
        assign w_sel = w_accept && (bus.cfg_ch == CH_W'(c));

`ifdef NCO_DITHER_EN
        logic [31:0] w_dbl;
        logic [15:0] w_rot;
        assign w_dbl = {r_lfsr, r_lfsr};
        assign w_rot = w_dbl[16 - (c % 16) +: 16];
        assign w_p   = r_acc + r_poff + ACC_W'(w_rot[DW-1:0]);
`else
        assign w_p = r_acc + r_poff;
`endif
        assign w_unused_p = ^w_p[ACC_W-ADDR_W-1:0];

        // Sync outranks the step; a coincident sample still uses old state
        always_ff @(posedge M100CLK or posedge reset) begin
            if (reset) begin
                r_acc  <= '0;
                r_freq <= '0;
                r_poff <= '0;
            end else begin
                if (w_accept && bus.cfg_sync) r_acc <= '0;
                else if (bus.en)              r_acc <= r_acc + r_freq;
                if (w_sel) begin
                    r_freq <= bus.cfg_freq;
                    r_poff <= bus.cfg_phase;
                end
            end
        end

        always_ff @(posedge M100CLK or posedge reset) begin
            if (reset)       r_addr <= '0;
            else if (bus.en) r_addr <= w_p[ACC_W-1 -: ADDR_W];
        end

        assign w_addr_c = r_addr + ADDR_W'(Q);
        assign w_idx_s  = fold(r_addr);
        assign w_idx_c  = fold(w_addr_c);

        nco_quarter_lut #(
            .ADDR_W (ADDR_W),
            .OUT_W  (OUT_W)
        ) u_lut (
            .i_clk   (M100CLK),
            .i_idx_s (w_idx_s),
            .i_idx_c (w_idx_c),
            .o_mag_s (w_mag_s),
            .o_mag_c (w_mag_c)
        );

        // Lower half of the circle carries the sign
        always_ff @(posedge M100CLK or posedge reset) begin
            if (reset) begin
                r_neg_s <= 1'b0;
                r_neg_c <= 1'b0;
            end else begin
                r_neg_s <= r_addr[ADDR_W-1];
                r_neg_c <= w_addr_c[ADDR_W-1];
            end
        end

        always_ff @(posedge M100CLK or posedge reset) begin
            if (reset) begin
                r_sin <= '0;
                r_cos <= '0;
            end else if (r_vld[1]) begin
                r_sin <= r_neg_s ? OUT_W'(0) - {1'b0, w_mag_s} : {1'b0, w_mag_s};
                r_cos <= r_neg_c ? OUT_W'(0) - {1'b0, w_mag_c} : {1'b0, w_mag_c};
            end
        end

        assign bus.sin[c*OUT_W +: OUT_W] = r_sin;
        assign bus.cos[c*OUT_W +: OUT_W] = r_cos;
    end

endmodule

// File: tb/tb_nco_multi.sv
// tb_nco_multi: directed self-checking bench for nco_multi (3 channels).
// Expected samples are hand-computed multiples of 45 degrees and LUT entries.
module tb_nco_multi;

    localparam int NCH = 3;
    localparam int AW  = 32;
    localparam int LW  = 12;
    localparam int OW  = 17;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    // sin at k*45 degrees; cos(k) = SIN8[(k+2)%8]
    int SIN8 [8] = '{0, 46340, 65535, 46340, 0, -46340, -65535, -46340};

    nco_multi_if #(.NUM_CH(NCH), .ACC_W(AW), .OUT_W(OW)) bus ();

    nco_multi #(
        .NUM_CH (NCH),
        .ACC_W  (AW),
        .ADDR_W (LW),
        .OUT_W  (OW)
    ) dut (
        .M100CLK (clk),
        .reset   (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic int s_of(input int c);
        logic [OW-1:0] v;
        v = bus.sin[c*OW +: OW];
        return int'($signed(v));
    endfunction

    function automatic int c_of(input int c);
        logic [OW-1:0] v;
        v = bus.cos[c*OW +: OW];
        return int'($signed(v));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.en = 1'b0;
        repeat (3) step();
    endtask

    task automatic do_cfg(input int ch, input logic [31:0] f,
                          input logic [31:0] ph, input logic s);
        int w;
        w             = 0;
        bus.cfg_valid = 1'b1;
        bus.cfg_ch    = 2'(ch);
        bus.cfg_freq  = f;
        bus.cfg_phase = ph;
        bus.cfg_sync  = s;
        while (bus.cfg_ready !== 1'b1 && w < 4) begin
            step();
            w++;
        end
        n_chk++;
        if (bus.cfg_ready !== 1'b1)
            $display("FAIL cfg_ready_wait got %b want 1", bus.cfg_ready);
        else n_pass++;
        step();
        bus.cfg_valid = 1'b0;
        bus.cfg_sync  = 1'b0;
    endtask

    task automatic test_reset();
        bus.en        = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_ch    = '0;
        bus.cfg_freq  = '0;
        bus.cfg_phase = '0;
        bus.cfg_sync  = 1'b0;
        rst           = 1'b1;
        step();
        step();
        n_chk++;
        if (bus.out_valid !== 1'b0 || bus.sin !== '0 || bus.cos !== '0)
            $display("FAIL reset_out got v=%b sin=%h cos=%h want 0", bus.out_valid, bus.sin, bus.cos);
        else n_pass++;
        n_chk++;
        if (bus.cfg_ready !== 1'b0)
            $display("FAIL reset_ready got %b want 0", bus.cfg_ready);
        else n_pass++;
        rst = 1'b0;
        step();
        n_chk++;
        if (bus.cfg_ready !== 1'b1)
            $display("FAIL reset_ready_after got %b want 1", bus.cfg_ready);
        else n_pass++;
        n_chk++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL reset_valid_after got %b want 0", bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_quadrature();
        do_cfg(0, 32'h4000_0000, 32'h0, 1'b0);
        bus.en = 1'b1;
        step();
        step();
        n_chk++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL quad_latency got %b want 0", bus.out_valid);
        else n_pass++;
        step();
        for (int n = 0; n < 5; n++) begin
            n_chk++;
            if (bus.out_valid !== 1'b1 || s_of(0) != SIN8[(2*n)%8]
                || c_of(0) != SIN8[(2*n+2)%8])
                $display("FAIL quad_ch0 n=%0d got v=%b s=%0d c=%0d want v=1 s=%0d c=%0d",
                         n, bus.out_valid, s_of(0), c_of(0),
                         SIN8[(2*n)%8], SIN8[(2*n+2)%8]);
            else n_pass++;
            n_chk++;
            if (s_of(1) != 0 || c_of(1) != 65535)
                $display("FAIL quad_ch1 n=%0d got s=%0d c=%0d want s=0 c=65535",
                         n, s_of(1), c_of(1));
            else n_pass++;
            step();
        end
        drain();
        n_chk++;
        if (bus.out_valid !== 1'b0 || s_of(0) != -65535 || c_of(0) != 0)
            $display("FAIL quad_hold got v=%b s=%0d c=%0d want v=0 s=-65535 c=0",
                     bus.out_valid, s_of(0), c_of(0));
        else n_pass++;
    endtask

    task automatic test_offset();
        do_cfg(0, 32'h0, 32'h4000_0000, 1'b0);
        bus.en = 1'b1;
        repeat (3) step();
        for (int n = 0; n < 2; n++) begin
            n_chk++;
            if (s_of(0) != 65535 || c_of(0) != 0 || s_of(1) != 0 || c_of(1) != 65535)
                $display("FAIL offset n=%0d got s0=%0d c0=%0d s1=%0d c1=%0d want 65535 0 0 65535",
                         n, s_of(0), c_of(0), s_of(1), c_of(1));
            else n_pass++;
            step();
        end
        drain();
    endtask

    task automatic test_retune();
        int exp_u [8] = '{0, 2, 4, 6, 7, 0, 1, 2};
        do_cfg(0, 32'h4000_0000, 32'h0, 1'b1);
        bus.en = 1'b1;
        step();
        step();
        bus.cfg_valid = 1'b1;
        bus.cfg_ch    = 2'd0;
        bus.cfg_freq  = 32'h2000_0000;
        bus.cfg_phase = 32'h0;
        bus.cfg_sync  = 1'b0;
        n_chk++;
        if (bus.cfg_ready !== 1'b1)
            $display("FAIL retune_ready got %b want 1", bus.cfg_ready);
        else n_pass++;
        step();
        bus.cfg_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            n_chk++;
            if (bus.out_valid !== 1'b1 || s_of(0) != SIN8[exp_u[i]]
                || c_of(0) != SIN8[(exp_u[i]+2)%8])
                $display("FAIL retune i=%0d got v=%b s=%0d c=%0d want v=1 s=%0d c=%0d",
                         i, bus.out_valid, s_of(0), c_of(0),
                         SIN8[exp_u[i]], SIN8[(exp_u[i]+2)%8]);
            else n_pass++;
        end
        drain();
    endtask

    task automatic test_sync();
        do_cfg(1, 32'h4000_0000, 32'h0, 1'b0);
        bus.en = 1'b1;
        repeat (3) step();
        bus.cfg_valid = 1'b1;
        bus.cfg_ch    = 2'd0;
        bus.cfg_freq  = 32'h2000_0000;
        bus.cfg_phase = 32'h0;
        bus.cfg_sync  = 1'b1;
        step();
        bus.cfg_valid = 1'b0;
        bus.cfg_sync  = 1'b0;
        n_chk++;
        if (bus.cfg_ready !== 1'b0)
            $display("FAIL sync_ready_low got %b want 0", bus.cfg_ready);
        else n_pass++;
        step();
        n_chk++;
        if (bus.cfg_ready !== 1'b1)
            $display("FAIL sync_ready_back got %b want 1", bus.cfg_ready);
        else n_pass++;
        step();
        step();
        for (int c = 0; c < NCH; c++) begin
            n_chk++;
            if (s_of(c) != 0 || c_of(c) != 65535)
                $display("FAIL sync_zero ch%0d got s=%0d c=%0d want s=0 c=65535",
                         c, s_of(c), c_of(c));
            else n_pass++;
        end
        step();
        n_chk++;
        if (s_of(0) != 46340 || c_of(0) != 46340 || s_of(1) != 65535
            || c_of(1) != 0 || s_of(2) != 0 || c_of(2) != 65535)
            $display("FAIL sync_next got %0d %0d %0d %0d %0d %0d want 46340 46340 65535 0 0 65535",
                     s_of(0), c_of(0), s_of(1), c_of(1), s_of(2), c_of(2));
        else n_pass++;
        drain();
    endtask

    task automatic test_wrap();
        do_cfg(0, 32'hFFFF_FFFF, 32'h0, 1'b1);
        bus.en = 1'b1;
        repeat (3) step();
        n_chk++;
        if (s_of(0) != 0 || c_of(0) != 65535)
            $display("FAIL wrap_s0 got s=%0d c=%0d want s=0 c=65535", s_of(0), c_of(0));
        else n_pass++;
        for (int n = 0; n < 2; n++) begin
            step();
            n_chk++;
            if (s_of(0) != -101 || c_of(0) != 65535)
                $display("FAIL wrap_s%0d got s=%0d c=%0d want s=-101 c=65535",
                         n + 1, s_of(0), c_of(0));
            else n_pass++;
        end
        drain();
        do_cfg(NCH, 32'h0, 32'h4000_0000, 1'b1);
        bus.en = 1'b1;
        repeat (3) step();
        for (int c = 0; c < NCH; c++) begin
            n_chk++;
            if (s_of(c) != 0 || c_of(c) != 65535)
                $display("FAIL oor_zero ch%0d got s=%0d c=%0d want s=0 c=65535",
                         c, s_of(c), c_of(c));
            else n_pass++;
        end
        step();
        n_chk++;
        if (s_of(0) != -101 || c_of(0) != 65535 || s_of(1) != 65535
            || c_of(1) != 0 || s_of(2) != 0 || c_of(2) != 65535)
            $display("FAIL oor_next got %0d %0d %0d %0d %0d %0d want -101 65535 65535 0 0 65535",
                     s_of(0), c_of(0), s_of(1), c_of(1), s_of(2), c_of(2));
        else n_pass++;
        drain();
    endtask

    task automatic test_reset_mid();
        bus.en = 1'b1;
        repeat (4) step();
        n_chk++;
        if (bus.out_valid !== 1'b1)
            $display("FAIL mid_pre_valid got %b want 1", bus.out_valid);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_chk++;
        if (bus.out_valid !== 1'b0 || bus.sin !== '0 || bus.cos !== '0)
            $display("FAIL mid_async got v=%b sin=%h cos=%h want 0", bus.out_valid, bus.sin, bus.cos);
        else n_pass++;
        bus.en = 1'b0;
        step();
        rst = 1'b0;
        n_chk++;
        if (bus.cfg_ready !== 1'b0)
            $display("FAIL mid_ready_rst got %b want 0", bus.cfg_ready);
        else n_pass++;
        step();
        n_chk++;
        if (bus.cfg_ready !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL mid_release got rdy=%b v=%b want rdy=1 v=0", bus.cfg_ready, bus.out_valid);
        else n_pass++;
        bus.en = 1'b1;
        step();
        step();
        n_chk++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL mid_no_stale got %b want 0", bus.out_valid);
        else n_pass++;
        step();
        n_chk++;
        if (bus.out_valid !== 1'b1 || s_of(0) != 0 || c_of(0) != 65535
            || s_of(1) != 0 || c_of(1) != 65535)
            $display("FAIL mid_first got v=%b s0=%0d c0=%0d s1=%0d c1=%0d want 1 0 65535 0 65535",
                     bus.out_valid, s_of(0), c_of(0), s_of(1), c_of(1));
        else n_pass++;
        drain();
    endtask

    initial begin
        test_reset();
        test_quadrature();
        test_offset();
        test_retune();
        test_sync();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
